// File: rtl/mystery2_frame_sink.sv
// Frame sink for the five-phase scrambler: captures the phase-3 word, checks it
// against the phase-4 parity word and queues {word, ok} records for a consumer.
module mystery2_frame_sink #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_word,
    output logic             out_ok,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             overflow
);
    // state | meaning
    // PH0   | in_word holds upstream phase 0 result (ignored)
    // PH1   | in_word holds upstream phase 1 result (ignored)
    // PH2   | in_word holds upstream phase 2 result (ignored)
    // PH3   | in_word holds the scrambled word; captured
    // PH4   | in_word holds the parity word; frame completes
    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4
    } phase_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    phase_t           r_ph;
    phase_t           w_ph_next;
    logic [15:0]      r_cap;
    logic [16:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_overflow;

    logic w_capture;
    logic w_frame;
    logic w_ok;
    logic w_full;
    logic w_pop;
    logic w_push;

    always_comb begin
        w_ph_next = PH0;
        w_capture = 1'b0;
        w_frame   = 1'b0;
        case (r_ph)
            PH0: w_ph_next = PH1;
            PH1: w_ph_next = PH2;
            PH2: w_ph_next = PH3;
            PH3: begin
                w_ph_next = PH4;
                w_capture = 1'b1;
            end
            PH4: begin
                w_ph_next = PH0;
                w_frame   = 1'b1;
            end
            default: w_ph_next = PH0;
        endcase
    end

    assign w_ok      = (in_word[15:1] == 15'd0) && (in_word[0] == ^r_cap);
    assign out_valid = (r_count != CW'(0));
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = out_valid && out_ready;
    // A pop at full frees the slot in the same edge, so the push still lands.
    assign w_push    = w_frame && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ph        <= PH0;
            r_cap       <= 16'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_ph <= w_ph_next;
            if (w_capture) r_cap <= in_word;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
            if (w_frame) begin
                if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                if (!w_ok && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
                if (!w_push) r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wr_ptr] <= {r_cap, w_ok};
    end

    assign out_word  = out_valid ? r_mem[r_rd_ptr][16:1] : 16'd0;
    assign out_ok    = out_valid ? r_mem[r_rd_ptr][0] : 1'b0;
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_mystery2_frame_sink.sv
// Bench for mystery2_frame_sink: queue-based reference model checked every cycle,
// a table of single-frame vectors, and hand sequences for FIFO/reset corners.
module tb_mystery2_frame_sink;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [15:0]      in_word = 16'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_word;
    logic             out_ok;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             overflow;

    mystery2_frame_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_ok(out_ok),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: records as {word, ok} in a queue, phase as a count mod 5
    logic [16:0] m_q[$];
    int          m_ph;
    logic [15:0] m_cap;
    int          m_frames, m_errs;
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("out_word", 32'(out_word), (m_q.size() > 0) ? 32'(m_q[0][16:1]) : 32'd0);
        chk("out_ok", 32'(out_ok), (m_q.size() > 0) ? 32'(m_q[0][0]) : 32'd0);
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        chk("err_cnt", 32'(err_cnt), 32'(m_errs));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_word = 16'($urandom);
        out_ready = 1'($urandom);
        @(posedge clk);
        #1;
        m_q.delete();
        m_ph = 0; m_cap = 16'd0; m_frames = 0; m_errs = 0; m_ovf = 1'b0;
        check_model();
    endtask

    task automatic step(input logic [15:0] w, input logic rdy);
        logic pop, ok;
        @(negedge clk);
        reset = 1'b0;
        in_word = w;
        out_ready = rdy;
        pop = (m_q.size() > 0) && rdy;
        @(posedge clk);
        #1;
        if (pop) void'(m_q.pop_front());
        if (m_ph == 3) m_cap = w;
        if (m_ph == 4) begin
            ok = (w[15:1] == 15'd0) && (w[0] == ^m_cap);
            if (m_frames < MAXC) m_frames++;
            if (!ok && m_errs < MAXC) m_errs++;
            if (m_q.size() < DEPTH) m_q.push_back({m_cap, ok});
            else m_ovf = 1'b1;
        end
        m_ph = (m_ph + 1) % 5;
        check_model();
    endtask

    // rdy[k] is out_ready during phase k of the frame
    task automatic run_frame(input logic [15:0] w3, input logic [15:0] w4, input logic [4:0] rdy);
        for (int k = 0; k < 5; k++)
            step((k == 3) ? w3 : (k == 4) ? w4 : 16'($urandom), rdy[k]);
    endtask

    typedef struct {
        logic [15:0] w3;
        logic [15:0] w4;
        logic [15:0] exp_word;
        logic        exp_ok;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int nerr;
        logic [15:0] first_word;
        logic [15:0] w3;

        tbl[0] = '{16'hBADC, 16'h0000, 16'hBADC, 1'b1};
        tbl[1] = '{16'hBADC, 16'h0001, 16'hBADC, 1'b0};
        tbl[2] = '{16'hBADC, 16'h8001, 16'hBADC, 1'b0};
        tbl[3] = '{16'h0001, 16'h0001, 16'h0001, 1'b1};
        tbl[4] = '{16'h0001, 16'h0000, 16'h0001, 1'b0};
        tbl[5] = '{16'hFFFF, 16'h0002, 16'hFFFF, 1'b0};
        tbl[6] = '{16'h8000, 16'h0001, 16'h8000, 1'b1};

        // table vectors: one frame each, previous record popped at phase 0
        do_reset();
        nerr = 0;
        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].w3, tbl[i].w4, 5'b00001);
            if (!tbl[i].exp_ok) nerr++;
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_word", 32'(out_word), 32'(tbl[i].exp_word));
            chk("tbl_ok", 32'(out_ok), 32'(tbl[i].exp_ok));
            chk("tbl_frames", 32'(frame_cnt), 32'(i + 1));
            chk("tbl_errs", 32'(err_cnt), 32'(nerr));
        end

        // first record latency: invisible after 4 edges, visible after the 5th
        do_reset();
        for (int k = 0; k < 4; k++) step((k == 3) ? 16'h1234 : 16'h0, 1'b0);
        chk("lat_before", 32'(out_valid), 32'd0);
        step(16'h0001, 1'b0);
        chk("lat_after", 32'(out_valid), 32'd1);
        chk("lat_word", 32'(out_word), 32'h1234);

        // overflow: DEPTH+1 frames with no consumer, then drain
        do_reset();
        first_word = 16'h5A5A;
        run_frame(first_word, 16'h0, 5'b0);
        for (int f = 1; f <= DEPTH; f++) begin
            chk("ovf_head", 32'(out_word), 32'(first_word));
            run_frame(16'($urandom), 16'($urandom_range(1, 0)), 5'b0);
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head_end", 32'(out_word), 32'(first_word));
        for (int k = 0; k < DEPTH; k++) step(16'($urandom), 1'b1);
        chk("ovf_drained", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // full FIFO, pop on the phase-4 edge: push succeeds, no overflow
        do_reset();
        for (int f = 0; f < DEPTH; f++) run_frame(16'($urandom), 16'h0, 5'b0);
        run_frame(16'hC0DE, 16'h0001, 5'b10000);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            chk("fullpp_occ", 32'(out_valid), 32'd1);
            step(16'h0, 1'b1);
        end
        chk("fullpp_empty", 32'(out_valid), 32'd0);

        // reset at phase 2 with two records queued
        do_reset();
        run_frame(16'h1111, 16'h0, 5'b0);
        run_frame(16'h2222, 16'h0, 5'b0);
        step(16'h0, 1'b0);
        step(16'h0, 1'b0);
        do_reset();
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_frames", 32'(frame_cnt), 32'd0);
        for (int k = 0; k < 4; k++) step((k == 3) ? 16'h00F0 : 16'hFFFF, 1'b0);
        chk("mid_lat_before", 32'(out_valid), 32'd0);
        step(16'h0000, 1'b0);
        chk("mid_lat_after", 32'(out_valid), 32'd1);
        chk("mid_ok", 32'(out_ok), 32'd1);

        // randomized frames and consumer back-pressure
        do_reset();
        for (int f = 0; f < 200; f++) begin
            w3 = 16'($urandom);
            for (int k = 0; k < 5; k++) begin
                logic [15:0] w;
                w = 16'($urandom);
                if (k == 3) w = w3;
                if (k == 4 && $urandom_range(3, 0) != 0)
                    w = {15'd0, (^w3) ^ ($urandom_range(7, 0) == 0)};
                step(w, 1'($urandom_range(2, 0) != 0));
            end
        end

        // saturation over 300 frames
        do_reset();
        for (int f = 0; f < 300; f++) run_frame(16'($urandom), 16'($urandom), 5'b11111);
        chk("sat_frames", 32'(frame_cnt), 32'(MAXC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
